spi_flash_read_ctrl: RTL

- QSPI flash read master. Accepts read requests of 1–256 bytes and issues the matching flash read instruction: READ, FAST_READ, QUAD_O_FAST_READ or QUAD_IO_FAST_READ, in 3- or 4-byte address form.
- Generates sck and cs, sequences the command, address, dummy and data phases, and returns bytes on a valid/ready stream.
- Sits between the ROM/boot fetch logic and the off-chip flash pins. Uses SPI mode 0 (CPOL=0, CPHA=0).

---
 rtl/spi_flash_read_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_read_ctrl.sv
// QSPI flash read master: sequences command, address, dummy and data phases
// for READ / FAST_READ / QUAD_O / QUAD_IO (3- or 4-byte address) in SPI mode 0.
module spi_flash_read_ctrl #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_addr4,
  input  logic [1:0]  req_mode,
  input  logic [7:0]  req_len,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_data,
  output logic        resp_last,
  output logic        sck,
  output logic        cs,
  output logic [3:0]  dq_out,
  output logic [3:0]  dq_drive,
  input  logic [3:0]  dq_in
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] CMD      = 3'd2;
  localparam logic [2:0] ADDR     = 3'd3;
  localparam logic [2:0] DUMMY    = 3'd4;
  localparam logic [2:0] DATA     = 3'd5;
  localparam logic [2:0] CS_HOLD  = 3'd6;
  localparam logic [2:0] DESELECT = 3'd7;

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic [7:0]    bitcnt;
  logic [8:0]    bytecnt;
  logic [39:0]   shreg;
  logic [7:0]    rx;
  logic [1:0]    mode_q;
  logic          addr4_q;
  logic [7:0]    len_q;

  logic          tick;
  logic          quad_addr;
  logic          quad_data;
  logic [7:0]    alen;
  logic          byte_end;
  logic [7:0]    rx_next;
  logic          stall;
  logic          all_done;
  logic [39:0]   sh_nxt;
  logic [7:0]    opcode;

  assign tick      = (tcnt == TW'(CLK_DIV - 1));
  assign quad_addr = (mode_q == 2'd3);
  assign quad_data = mode_q[1];
  assign byte_end  = quad_data ? (bitcnt == 8'd1) : (bitcnt == 8'd7);
  assign all_done  = (bytecnt == ({1'b0, len_q} + 9'd1));
  assign req_ready = (state == IDLE) && !resp_valid && !reset;

  // A completing rise with the previous byte still unaccepted would overwrite it,
  // so sck and the timer freeze until the consumer takes it.
  assign stall = (state == DATA) && !sck && byte_end && resp_valid && !resp_ready;

  always_comb begin
    alen = '0;
    if (quad_addr) alen = addr4_q ? 8'd8 : 8'd6;
    else           alen = addr4_q ? 8'd32 : 8'd24;
    rx_next = quad_data ? {rx[3:0], dq_in} : {rx[6:0], dq_in[1]};
    sh_nxt  = (state == ADDR && quad_addr) ? {shreg[35:0], 4'b0000} : {shreg[38:0], 1'b0};
    opcode  = '0;
    case (req_mode)
      2'd0:    opcode = req_addr4 ? 8'h13 : 8'h03;
      2'd1:    opcode = req_addr4 ? 8'h0C : 8'h0B;
      2'd2:    opcode = req_addr4 ? 8'h6C : 8'h6B;
      default: opcode = req_addr4 ? 8'hEC : 8'hEB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cs         <= 1'b1;
      sck        <= 1'b0;
      dq_out     <= '0;
      dq_drive   <= '0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_data  <= '0;
      tcnt       <= '0;
      bitcnt     <= '0;
      bytecnt    <= '0;
      shreg      <= '0;
      rx         <= '0;
      mode_q     <= '0;
      addr4_q    <= 1'b0;
      len_q      <= '0;
    end else begin
      if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        resp_last  <= 1'b0;
      end
      if (state != IDLE && !stall) tcnt <= tick ? '0 : tcnt + TW'(1);

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            mode_q   <= req_mode;
            addr4_q  <= req_addr4;
            len_q    <= req_len;
            // opcode and address share one shifter; a 3-byte address is left-justified
            shreg    <= {opcode, req_addr4 ? req_addr : {req_addr[23:0], 8'h00}};
            dq_out   <= {3'b000, opcode[7]};
            dq_drive <= 4'b0001;
            cs       <= 1'b0;
            tcnt     <= '0;
            bitcnt   <= '0;
            bytecnt  <= '0;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: if (tick) state <= CMD;
        CMD, ADDR, DUMMY, DATA: begin
          if (tick && !stall) begin
            if (!sck) begin
              sck    <= 1'b1;
              bitcnt <= bitcnt + 8'd1;
              if (state == DATA) begin
                rx <= rx_next;
                if (byte_end) begin
                  resp_data  <= rx_next;
                  resp_valid <= 1'b1;
                  resp_last  <= (bytecnt[7:0] == len_q);
                  bytecnt    <= bytecnt + 9'd1;
                  bitcnt     <= '0;
                end
              end
            end else begin
              sck   <= 1'b0;
              shreg <= sh_nxt;
              case (state)
                CMD: begin
                  if (bitcnt == 8'd8) begin
                    state    <= ADDR;
                    bitcnt   <= '0;
                    dq_out   <= quad_addr ? sh_nxt[39:36] : {3'b000, sh_nxt[39]};
                    dq_drive <= quad_addr ? 4'b1111 : 4'b0001;
                  end else begin
                    dq_out <= {3'b000, sh_nxt[39]};
                  end
                end
                ADDR: begin
                  if (bitcnt == alen) begin
                    state    <= (mode_q == 2'd0) ? DATA : DUMMY;
                    bitcnt   <= '0;
                    dq_out   <= '0;
                    dq_drive <= '0;
                  end else begin
                    dq_out <= quad_addr ? sh_nxt[39:36] : {3'b000, sh_nxt[39]};
                  end
                end
                DUMMY: begin
                  if (bitcnt == 8'(DUMMY_CYCLES)) begin
                    state  <= DATA;
                    bitcnt <= '0;
                  end
                end
                DATA:    if (all_done) state <= CS_HOLD;
                default: ;
              endcase
            end
          end
        end
        CS_HOLD: begin
          if (tick) begin
            cs     <= 1'b1;
            bitcnt <= '0;
            state  <= DESELECT;
          end
        end
        DESELECT: begin
          if (tick) begin
            if (bitcnt == 8'd1) state <= IDLE;
            else                bitcnt <= bitcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
